pool_window_buffer: RTL and testbench

POOL_WINDOW_BUFFER -- requirements
Module: pool_window_buffer

---
 rtl/pool_window_buffer_if.sv | 36 +++
 rtl/pool_window_buffer.sv | 195 +++++++++++++++++++
 tb/tb_pool_window_buffer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_window_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pool_window_buffer_if
//  Purpose  : Stream bundle for the 2x2 pooling window buffer.
//             Input side : in_valid / in_ready / in_pixel (row-major pixels)
//             Output side: win_valid / win_ready / win_p00..win_p11 / win_last
//             master = producer of pixels and consumer of windows
//             slave  = the window buffer itself
//  Revision : 1.0  initial release
// ============================================================================
interface pool_window_buffer_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_pixel;
  logic         win_valid;
  logic         win_ready;
  logic [W-1:0] win_p00;
  logic [W-1:0] win_p01;
  logic [W-1:0] win_p10;
  logic [W-1:0] win_p11;
  logic         win_last;

  modport master (
    output in_valid, in_pixel, win_ready,
    input  in_ready, win_valid, win_p00, win_p01, win_p10, win_p11, win_last
  );

  modport slave (
    input  in_valid, in_pixel, win_ready,
    output in_ready, win_valid, win_p00, win_p01, win_p10, win_p11, win_last
  );
endinterface
`default_nettype wire

// File: rtl/pool_window_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pool_window_buffer
//  Purpose  : Converts a row-major N x N pixel stream into non-overlapping
//             2x2 windows for a downstream pooling stage. Even rows are
//             parked in a one-row line buffer; odd rows pair with it to emit
//             one window per two odd-row pixels.
//  Ports    : clk, rst_n (async, active-low)
//             start  - pulse to begin a map (IDLE only)
//             busy   - high from accepted start until done
//             done   - one-cycle pulse after the last window transfers
//             bus    - pool_window_buffer_if.slave (pixel in / window out)
//  Revision : 1.0  initial release
// ============================================================================
module pool_window_buffer #(
  parameter int N = 28,
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  pool_window_buffer_if.slave    bus
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [W-1:0]  p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Not reset: only ever read after being rewritten within the current map.
  logic [W-1:0]  line_buf [N];
  logic [W-1:0]  side_q;

  logic          in_ready_w;
  logic          in_xfer;
  logic          out_xfer;
  logic          buf_we;
  logic          side_we;
  logic [CW-1:0] pair_col;

  // In odd rows a pixel may only enter if the single output slot is free or
  // emptying this cycle; that keeps full throughput without an overflow.
  assign in_ready_w = (state_q == EVEN_ROW) ||
                      ((state_q == ODD_ROW) && (!win_valid_q || bus.win_ready));
  assign in_xfer    = bus.in_valid && in_ready_w;
  assign out_xfer   = win_valid_q && bus.win_ready;
  assign pair_col   = col_q & ~ONE;   // left column of the current pair

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    p00_d       = p00_q;
    p01_d       = p01_q;
    p10_d       = p10_q;
    p11_d       = p11_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    buf_we      = 1'b0;
    side_we     = 1'b0;

    // Emptying first; a same-cycle load below overrides it.
    if (out_xfer) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EVEN_ROW;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
        end
      end

      EVEN_ROW: begin
        if (in_xfer) begin
          buf_we = 1'b1;
          if (col_q == LAST_IDX) begin
            // row tracks the actual pixel row, so it also steps here
            col_d   = '0;
            row_d   = row_q + ONE;
            state_d = ODD_ROW;
          end else begin
            col_d = col_q + ONE;
          end
        end
      end

      ODD_ROW: begin
        if (in_xfer) begin
          if (!col_q[0]) begin
            side_we = 1'b1;
          end else begin
            p00_d       = line_buf[pair_col];
            p01_d       = line_buf[col_q];
            p10_d       = side_q;
            p11_d       = bus.in_pixel;
            win_valid_d = 1'b1;
            win_last_d  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
          end
          if (col_q == LAST_IDX) begin
            col_d = '0;
            if (row_q == LAST_IDX) begin
              state_d = DRAIN;
            end else begin
              row_d   = row_q + ONE;
              state_d = EVEN_ROW;
            end
          end else begin
            col_d = col_q + ONE;
          end
        end
      end

      DRAIN: begin
        // Only the final window can be held here.
        if (out_xfer && win_last_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      p00_q       <= '0;
      p01_q       <= '0;
      p10_q       <= '0;
      p11_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      p00_q       <= p00_d;
      p01_q       <= p01_d;
      p10_q       <= p10_d;
      p11_q       <= p11_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we)  line_buf[col_q] <= bus.in_pixel;
    if (side_we) side_q          <= bus.in_pixel;
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.win_p00   = p00_q;
  assign bus.win_p01   = p01_q;
  assign bus.win_p10   = p10_q;
  assign bus.win_p11   = p11_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_window_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pool_window_buffer
//  Purpose  : Directed self-checking bench for pool_window_buffer with three
//             instances (N=4, N=2, N=28).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pool_window_buffer;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] pk(input int a, input int b, input int c, input int d, input bit l);
    logic [79:0] r;
    r = {15'b0, l, a[15:0], b[15:0], c[15:0], d[15:0]};
    return r;
  endfunction

  // ---------------- DUT instances ----------------
  pool_window_buffer_if #(.W(W)) b4 ();
  pool_window_buffer_if #(.W(W)) b2 ();
  pool_window_buffer_if #(.W(W)) b28 ();
  logic start4, start2, start28;
  logic busy4, busy2, busy28, done4, done2, done28;

  pool_window_buffer #(.N(4), .W(W)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4), .bus(b4));
  pool_window_buffer #(.N(2), .W(W)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .bus(b2));
  pool_window_buffer #(.N(28), .W(W)) u_dut28 (
    .clk(clk), .rst_n(rst_n), .start(start28), .busy(busy28), .done(done28), .bus(b28));

  function automatic logic [79:0] cur4();
    return {15'b0, b4.win_last, b4.win_p00, b4.win_p01, b4.win_p10, b4.win_p11};
  endfunction

  // ---------------- monitors ----------------
  logic [79:0] q4[$];
  logic [79:0] q2[$];
  logic [79:0] e28[$];
  int done4_cnt = 0, done2_cnt = 0, done28_cnt = 0, win28_cnt = 0;
  int last4_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (b4.win_valid && b4.win_ready) begin
        q4.push_back(cur4());
        if (b4.win_last) last4_cyc = cyc;
      end
      if (done4) begin
        done4_cnt++;
        check("done4_lat", cyc, last4_cyc + 1);
      end
      if (b2.win_valid && b2.win_ready)
        q2.push_back({15'b0, b2.win_last, b2.win_p00, b2.win_p01, b2.win_p10, b2.win_p11});
      if (done2) done2_cnt++;
      if (b28.win_valid && b28.win_ready) begin
        win28_cnt++;
        if (e28.size() == 0)
          check("w28_extra", e28.size(), 1);
        else
          check("w28", {15'b0, b28.win_last, b28.win_p00, b28.win_p01, b28.win_p10, b28.win_p11},
                e28.pop_front());
      end
      if (done28) done28_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic rdy(input int id);
    case (id)
      4:       return b4.in_ready;
      2:       return b2.in_ready;
      default: return b28.in_ready;
    endcase
  endfunction

  task automatic set_in(input int id, input logic v, input int pix);
    case (id)
      4:       begin b4.in_valid  = v; b4.in_pixel  = pix[15:0]; end
      2:       begin b2.in_valid  = v; b2.in_pixel  = pix[15:0]; end
      default: begin b28.in_valid = v; b28.in_pixel = pix[15:0]; end
    endcase
  endtask

  task automatic send(input int id, input int pix);
    int t;
    t = 0;
    set_in(id, 1'b1, pix);
    forever begin
      @(negedge clk);
      if (rdy(id)) break;
      t++;
      if (t > 100) begin
        check("send_timeout", t, 0);
        break;
      end
    end
    @(posedge clk); #1;
    set_in(id, 1'b0, 0);
  endtask

  task automatic pulse_start(input int id);
    case (id)
      4:       start4  = 1'b1;
      2:       start2  = 1'b1;
      default: start28 = 1'b1;
    endcase
    @(posedge clk); #1;
    start4 = 1'b0; start2 = 1'b0; start28 = 1'b0;
  endtask

  task automatic wait_done4(input int prev, input string tag);
    int t;
    t = 0;
    while (done4_cnt == prev && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, done4_cnt, prev + 1);
    check({tag, "_busy_lo"}, busy4, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_q4(input string tag, input int base);
    int offs[4];
    offs = '{0, 2, 8, 10};
    check({tag, "_nwin"}, q4.size(), 4);
    for (int i = 0; i < 4 && i < q4.size(); i++)
      check({tag, "_win"}, q4[i],
            pk(base + offs[i], base + offs[i] + 1, base + offs[i] + 4, base + offs[i] + 5, i == 3));
  endtask

  int px[28][28];

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [79:0] snap;
    int prev, w0, t;
    start4 = 0; start2 = 0; start28 = 0;
    b4.in_valid = 0;  b4.in_pixel = 0;  b4.win_ready = 0;
    b2.in_valid = 0;  b2.in_pixel = 0;  b2.win_ready = 1;
    b28.in_valid = 0; b28.in_pixel = 0; b28.win_ready = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", b4.in_ready, 0);
    check("rst_win_valid", b4.win_valid, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_win_regs", cur4(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous stream, no backpressure
    b4.win_ready = 1;
    prev = done4_cnt;
    pulse_start(4);
    check("basic_busy_hi", busy4, 1);
    for (int i = 0; i < 16; i++) send(4, i);
    wait_done4(prev, "basic");
    check_q4("basic", 0);

    // Backpressure on the first window
    q4.delete();
    b4.win_ready = 0;
    prev = done4_cnt;
    fork
      begin
        pulse_start(4);
        for (int i = 0; i < 16; i++) send(4, i);
      end
      begin
        t = 0;
        while (!b4.win_valid && t < 200) begin
          @(negedge clk);
          t++;
        end
        check("bp_wvalid", b4.win_valid, 1);
        snap = cur4();
        check("bp_first", snap, pk(0, 1, 4, 5, 1'b0));
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_hold", cur4(), snap);
          check("bp_in_ready", b4.in_ready, 0);
        end
        @(posedge clk); #1;
        b4.win_ready = 1;
      end
    join
    wait_done4(prev, "bp");
    check_q4("bp", 0);

    // in_valid in IDLE and start mid-map are ignored
    q4.delete();
    b4.in_valid = 1; b4.in_pixel = 16'd77;
    repeat (3) @(negedge clk);
    check("idle_in_ready", b4.in_ready, 0);
    check("idle_busy", busy4, 0);
    @(posedge clk); #1;
    b4.in_valid = 0;
    prev = done4_cnt;
    pulse_start(4);
    send(4, 0);
    send(4, 1);
    pulse_start(4);
    for (int i = 2; i < 16; i++) send(4, i);
    wait_done4(prev, "ign");
    check_q4("ign", 0);

    // Reset in the middle of a map, then a fresh map
    pulse_start(4);
    for (int i = 0; i < 10; i++) send(4, i);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wvalid", b4.win_valid, 0);
    check("mid_rst_regs", cur4(), 0);
    check("mid_rst_busy", busy4, 0);
    check("mid_rst_in_ready", b4.in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q4.delete();
    @(posedge clk); #1;
    prev = done4_cnt;
    pulse_start(4);
    for (int i = 100; i < 116; i++) send(4, i);
    wait_done4(prev, "rst");
    check_q4("rst", 100);

    // N=2, signed extremes
    pulse_start(2);
    send(2, -1);
    send(2, -32768);
    send(2, 32767);
    send(2, 0);
    t = 0;
    while (done2_cnt == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("n2_done_cnt", done2_cnt, 1);
    check("n2_nwin", q2.size(), 1);
    if (q2.size() > 0) check("n2_win", q2[0], pk(-1, -32768, 32767, 0, 1'b1));
    @(posedge clk); #1;

    // N=28, throttled input and output
    for (int m = 0; m < 20; m++) begin
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++)
          px[r][c] = int'($urandom_range(0, 65535));
      for (int r = 0; r < 28; r += 2)
        for (int c = 0; c < 28; c += 2)
          e28.push_back(pk(px[r][c], px[r][c+1], px[r+1][c], px[r+1][c+1], (r == 26) && (c == 26)));
      prev = done28_cnt;
      w0   = win28_cnt;
      pulse_start(28);
      fork
        begin
          for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
              repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
              end
              send(28, px[r][c]);
            end
        end
        begin
          t = 0;
          while (done28_cnt == prev && t < 20000) begin
            @(posedge clk); #1;
            b28.win_ready = ($urandom_range(0, 3) != 0);
            t++;
          end
        end
      join
      b28.win_ready = 0;
      check("m28_done", done28_cnt, prev + 1);
      check("m28_nwin", win28_cnt - w0, 196);
      check("m28_left", e28.size(), 0);
      e28.delete();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
